// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the 9-bit CPU sequencer: sequencer states, the decoder's
// ControlSignals bundle and the instruction opcode encoding.
package cpu_sequencer_pkg;

  localparam int INSTR_W = 9;
  localparam int OPC_W   = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD = 3'd0,
    OP_XOR = 3'd1,
    OP_LW  = 3'd2,
    OP_SW  = 3'd3,
    OP_BR  = 3'd4
  } opcode_t;

  typedef struct packed {
    logic branch;
    logic memRead;
    logic memWrite;
    logic writeEnable;
  } ControlSignals;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4,
    HALT  = 3'd5
  } seq_state_t;

  function automatic logic is_mem_op(input ControlSignals c);
    return c.memRead | c.memWrite;
  endfunction

endpackage

// File: rtl/cpu_sequencer_pc_unit.sv
// Program counter for the sequencer: holds pc, picks branch target or pc+1 on
// retire, and flags when the retiring instruction ends the program.
module cpu_sequencer_pc_unit #(
  parameter int PC_W     = 8,
  parameter int PROG_LEN = 256
) (
  input  logic            clk,
  input  logic            init_n,
  input  logic            clear_i,
  input  logic            retire_i,
  input  logic            taken_i,
  input  logic [PC_W-1:0] br_target_i,
  output logic [PC_W-1:0] pc_o,
  output logic            halt_o
);

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] next_pc;

  always_comb begin
    next_pc = taken_i ? br_target_i : pc_q + PC_W'(1);
    // A taken branch out of the last word keeps running.
    halt_o  = (pc_q == LAST_PC) && !taken_i;
    pc_d    = pc_q;
    if (clear_i) begin
      pc_d = '0;
    end else if (retire_i && !halt_o) begin
      pc_d = next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!init_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/EXEC/MEM/WB stepping, IR, memory
// handshake and a saturating retired-instruction counter.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int PROG_LEN = 256,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               init_n,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr_in,
  input  ControlSignals      ctrl_in,
  input  logic               alu_zero,
  input  logic [PC_W-1:0]    br_target,
  input  logic               mem_ack,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_load,
  output logic               reg_we,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   instr_count
);

  seq_state_t         state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               retire;
  logic               clear_pc;
  logic               taken;
  logic               halt_now;

  cpu_sequencer_pc_unit #(
    .PC_W     (PC_W),
    .PROG_LEN (PROG_LEN)
  ) u_pc_unit (
    .clk         (clk),
    .init_n      (init_n),
    .clear_i     (clear_pc),
    .retire_i    (retire),
    .taken_i     (taken),
    .br_target_i (br_target),
    .pc_o        (pc),
    .halt_o      (halt_now)
  );

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q;
    retire   = 1'b0;
    clear_pc = 1'b0;
    taken    = ctrl_in.branch && alu_zero;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d  = FETCH;
          clear_pc = 1'b1;
          cnt_d    = '0;
        end
      end
      FETCH: begin
        ir_d    = instr_in;
        state_d = EXEC;
      end
      EXEC: begin
        if (is_mem_op(ctrl_in)) begin
          state_d = MEM;
        end else if (ctrl_in.writeEnable) begin
          state_d = WB;
        end else begin
          retire = 1'b1;
        end
      end
      MEM: begin
        if (mem_ack) begin
          if (ctrl_in.memRead) begin
            state_d = WB;
          end else begin
            retire = 1'b1;
          end
        end
      end
      WB: begin
        retire = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (retire) begin
      cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      state_d = halt_now ? HALT : FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (!init_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes depend only on registered state (and the decoded IR in MEM).
  assign ir_load     = (state_q == FETCH);
  assign reg_we      = (state_q == WB);
  assign mem_rd      = (state_q == MEM) && ctrl_in.memRead;
  assign mem_wr      = (state_q == MEM) && ctrl_in.memWrite;
  assign busy        = (state_q == FETCH) || (state_q == EXEC) ||
                       (state_q == MEM)   || (state_q == WB);
  assign done        = (state_q == HALT);
  assign ir          = ir_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: vector table, directed corner cases
// and randomized programs checked against an instruction-level model.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  localparam int PC_W     = 3;
  localparam int PROG_LEN = 2;
  localparam int CNT_W    = 2;

  // Strobe order: {ir_load, reg_we, mem_rd, mem_wr, busy, done}
  localparam logic [5:0] S_IDLE  = 6'b000000;
  localparam logic [5:0] S_FETCH = 6'b100010;
  localparam logic [5:0] S_EXEC  = 6'b000010;
  localparam logic [5:0] S_MRD   = 6'b001010;
  localparam logic [5:0] S_MWR   = 6'b000110;
  localparam logic [5:0] S_WB    = 6'b010010;
  localparam logic [5:0] S_HALT  = 6'b000001;

  localparam logic [8:0] I_ADD = 9'b000_010_001;
  localparam logic [8:0] I_XOR = 9'b001_011_010;
  localparam logic [8:0] I_LW  = 9'b010_001_100;
  localparam logic [8:0] I_SW  = 9'b011_101_001;
  localparam logic [8:0] I_NOP = 9'b101_000_011;
  localparam logic [8:0] I_UND = 9'b110_111_111;

  logic               clk = 1'b0;
  logic               init_n = 1'b0;
  logic               start = 1'b0;
  logic [8:0]         instr_in;
  ControlSignals      ctrl_in;
  logic               alu_zero = 1'b0;
  logic [PC_W-1:0]    br_target;
  logic               mem_ack = 1'b0;
  logic [PC_W-1:0]    pc;
  logic [8:0]         ir;
  logic               ir_load, reg_we, mem_rd, mem_wr, busy, done;
  logic [CNT_W-1:0]   instr_count;

  logic [8:0] rom [8];
  int total = 0;
  int bad   = 0;

  function automatic ControlSignals dec(input logic [8:0] w);
    ControlSignals c;
    c = '0;
    case (w[8:6])
      3'd0, 3'd1: c.writeEnable = 1'b1;
      3'd2: begin c.memRead = 1'b1; c.writeEnable = 1'b1; end
      3'd3: c.memWrite = 1'b1;
      3'd4: c.branch = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [8:0] br(input logic [2:0] t);
    return {3'd4, 3'd0, t};
  endfunction

  assign instr_in  = rom[pc];
  assign ctrl_in   = dec(ir);
  assign br_target = ir[PC_W-1:0];

  cpu_sequencer #(
    .PC_W     (PC_W),
    .PROG_LEN (PROG_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .init_n      (init_n),
    .start       (start),
    .instr_in    (instr_in),
    .ctrl_in     (ctrl_in),
    .alu_zero    (alu_zero),
    .br_target   (br_target),
    .mem_ack     (mem_ack),
    .pc          (pc),
    .ir          (ir),
    .ir_load     (ir_load),
    .reg_we      (reg_we),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .busy        (busy),
    .done        (done),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic out_chk(input string nm, input logic [5:0] s, input logic [2:0] p,
                         input logic [1:0] c);
    logic [5:0] gs;
    gs = {ir_load, reg_we, mem_rd, mem_wr, busy, done};
    total++;
    if ({gs, pc, instr_count} !== {s, p, c}) begin
      bad++;
      $display("FAIL %s: got strobes(ld,we,rd,wr,busy,done)=%b pc=%0d cnt=%0d, want strobes=%b pc=%0d cnt=%0d",
               nm, gs, pc, instr_count, s, p, c);
    end
  endtask

  task automatic ir_chk(input string nm, input logic [8:0] exp);
    total++;
    if (ir !== exp) begin
      bad++;
      $display("FAIL %s: got ir=%h want ir=%h", nm, ir, exp);
    end
  endtask

  task automatic cyc(input string nm, input logic st, input logic az, input logic ack,
                     input logic [5:0] s, input logic [2:0] p, input logic [1:0] c);
    start    = st;
    alu_zero = az;
    mem_ack  = ack;
    step();
    out_chk(nm, s, p, c);
  endtask

  task automatic do_reset(input string nm);
    init_n   = 1'b0;
    start    = 1'($urandom % 2);
    mem_ack  = 1'($urandom % 2);
    step();
    init_n = 1'b1;
    start  = 1'b0;
    out_chk(nm, S_IDLE, 3'd0, 2'd0);
    ir_chk(nm, 9'd0);
  endtask

  function automatic logic rs();
    return ($urandom % 4) == 0;
  endfunction

  // Instruction-level reference: walks one instruction at a time from the
  // program rules and checks every cycle's outputs along the way.
  task automatic rnd_run(input int max_instr, output bit halted);
    logic [2:0]    mpc;
    logic [1:0]    mcnt;
    logic [8:0]    w;
    ControlSignals c;
    bit            taken;
    int            nmem;
    logic          ack;
    start = 1'b1; alu_zero = 1'($urandom); mem_ack = 1'($urandom);
    step();
    mpc = '0; mcnt = '0; halted = 1'b0;
    for (int k = 0; k < max_instr && !halted; k++) begin
      out_chk("rnd fetch", S_FETCH, mpc, mcnt);
      w = rom[mpc];
      start = rs(); alu_zero = 1'($urandom); mem_ack = 1'($urandom);
      step();
      out_chk("rnd exec", S_EXEC, mpc, mcnt);
      ir_chk("rnd ir", w);
      c = dec(w);
      taken = 1'b0;
      start = rs(); alu_zero = 1'($urandom); mem_ack = 1'($urandom);
      if (c.memRead || c.memWrite) begin
        step();
        nmem = 0;
        do begin
          out_chk("rnd mem", c.memRead ? S_MRD : S_MWR, mpc, mcnt);
          ack = (nmem >= 3) || (($urandom % 2) == 1);
          start = rs(); alu_zero = 1'($urandom); mem_ack = ack;
          nmem++;
          step();
        end while (!ack);
        if (c.memRead) begin
          out_chk("rnd lw wb", S_WB, mpc, mcnt);
          start = rs(); alu_zero = 1'($urandom); mem_ack = 1'($urandom);
          step();
        end
      end else if (c.writeEnable) begin
        step();
        out_chk("rnd alu wb", S_WB, mpc, mcnt);
        start = rs(); alu_zero = 1'($urandom); mem_ack = 1'($urandom);
        step();
      end else begin
        taken = c.branch && alu_zero;
        step();
      end
      mcnt = (mcnt == 2'd3) ? 2'd3 : mcnt + 2'd1;
      if (int'(mpc) == PROG_LEN - 1 && !taken) halted = 1'b1;
      else mpc = taken ? w[2:0] : mpc + 3'd1;
    end
    start = 1'b0;
    if (halted) out_chk("rnd halt", S_HALT, mpc, mcnt);
  endtask

  typedef struct {
    logic       st;
    logic       ack;
    logic [5:0] s;
    logic [2:0] p;
    logic [1:0] c;
  } vec_t;

  initial begin
    vec_t tv[15];
    bit   h;

    tv[0]  = '{1'b1, 1'b0, S_FETCH, 3'd0, 2'd0};
    tv[1]  = '{1'b0, 1'b1, S_EXEC,  3'd0, 2'd0};
    tv[2]  = '{1'b0, 1'b1, S_WB,    3'd0, 2'd0};
    tv[3]  = '{1'b0, 1'b0, S_FETCH, 3'd1, 2'd1};
    tv[4]  = '{1'b0, 1'b1, S_EXEC,  3'd1, 2'd1};
    tv[5]  = '{1'b0, 1'b0, S_WB,    3'd1, 2'd1};
    tv[6]  = '{1'b0, 1'b1, S_HALT,  3'd1, 2'd2};
    tv[7]  = '{1'b0, 1'b0, S_HALT,  3'd1, 2'd2};
    tv[8]  = '{1'b1, 1'b0, S_FETCH, 3'd0, 2'd0};
    tv[9]  = '{1'b1, 1'b0, S_EXEC,  3'd0, 2'd0};
    tv[10] = '{1'b1, 1'b1, S_WB,    3'd0, 2'd0};
    tv[11] = '{1'b0, 1'b0, S_FETCH, 3'd1, 2'd1};
    tv[12] = '{1'b1, 1'b0, S_EXEC,  3'd1, 2'd1};
    tv[13] = '{1'b1, 1'b0, S_WB,    3'd1, 2'd1};
    tv[14] = '{1'b0, 1'b0, S_HALT,  3'd1, 2'd2};

    for (int a = 0; a < 8; a++) rom[a] = I_NOP;
    step();
    step();

    // ADD at pc0, XOR at pc1, then restart from HALT with start pulses while busy
    rom[0] = I_ADD; rom[1] = I_XOR;
    do_reset("reset state");
    for (int i = 0; i < 15; i++) begin
      cyc($sformatf("table row %0d", i), tv[i].st, 1'b0, tv[i].ack, tv[i].s, tv[i].p, tv[i].c);
      if (i == 1) ir_chk("table ir add", I_ADD);
    end

    // LW with a 3-cycle memory wait
    rom[0] = I_LW; rom[1] = br(3'd0);
    do_reset("lw reset");
    cyc("lw fetch", 1, 0, 0, S_FETCH, 0, 0);
    cyc("lw exec",  0, 0, 1, S_EXEC,  0, 0);
    ir_chk("lw ir", I_LW);
    cyc("lw mem1",  0, 0, 1, S_MRD,   0, 0);
    cyc("lw mem2",  0, 0, 0, S_MRD,   0, 0);
    cyc("lw mem3",  0, 0, 0, S_MRD,   0, 0);
    cyc("lw wb",    0, 0, 1, S_WB,    0, 0);
    cyc("lw next",  0, 0, 0, S_FETCH, 1, 1);
    cyc("br exec",  0, 0, 0, S_EXEC,  1, 1);
    cyc("br halt",  0, 0, 0, S_HALT,  1, 2);

    // Branches: taken/untaken, saturating count, NOPs, wrap, taken from last pc
    rom[0] = br(3'd5); rom[5] = br(3'd2); rom[2] = br(3'd5);
    rom[6] = I_NOP; rom[7] = I_UND; rom[1] = br(3'd4);
    do_reset("br reset");
    cyc("br0 fetch", 1, 0, 0, S_FETCH, 0, 0);
    cyc("br0 exec",  0, 0, 0, S_EXEC,  0, 0);
    cyc("br0 taken", 0, 1, 0, S_FETCH, 5, 1);
    cyc("br5 exec",  0, 0, 0, S_EXEC,  5, 1);
    cyc("br5 taken", 0, 1, 0, S_FETCH, 2, 2);
    cyc("br2 exec",  0, 0, 0, S_EXEC,  2, 2);
    cyc("br2 taken", 0, 1, 0, S_FETCH, 5, 3);
    cyc("br5 exec2", 0, 0, 0, S_EXEC,  5, 3);
    cyc("br5 untkn", 0, 0, 0, S_FETCH, 6, 3);
    cyc("nop exec",  0, 0, 0, S_EXEC,  6, 3);
    cyc("nop ret",   0, 1, 1, S_FETCH, 7, 3);
    cyc("und exec",  0, 0, 0, S_EXEC,  7, 3);
    cyc("pc wrap",   0, 1, 0, S_FETCH, 0, 3);
    cyc("br0 exec2", 0, 0, 0, S_EXEC,  0, 3);
    cyc("br0 untkn", 0, 0, 0, S_FETCH, 1, 3);
    cyc("br1 exec",  0, 0, 0, S_EXEC,  1, 3);
    cyc("last tkn",  0, 1, 0, S_FETCH, 4, 3);

    // SW with mem_ack already high on MEM entry
    rom[0] = I_SW; rom[1] = br(3'd0);
    do_reset("sw reset");
    cyc("sw fetch", 1, 0, 1, S_FETCH, 0, 0);
    cyc("sw exec",  0, 0, 1, S_EXEC,  0, 0);
    cyc("sw mem",   0, 0, 1, S_MWR,   0, 0);
    cyc("sw ret",   0, 0, 1, S_FETCH, 1, 1);
    cyc("sw br ex", 0, 0, 0, S_EXEC,  1, 1);
    cyc("sw halt",  0, 0, 0, S_HALT,  1, 2);

    // Reset during a pending SW drops the request; ack afterwards is ignored
    rom[0] = I_ADD; rom[1] = I_SW;
    do_reset("rst reset");
    cyc("rst f0",  1, 0, 0, S_FETCH, 0, 0);
    cyc("rst e0",  0, 0, 0, S_EXEC,  0, 0);
    cyc("rst wb0", 0, 0, 0, S_WB,    0, 0);
    cyc("rst f1",  0, 0, 0, S_FETCH, 1, 1);
    cyc("rst e1",  0, 0, 0, S_EXEC,  1, 1);
    cyc("rst mem", 0, 0, 0, S_MWR,   1, 1);
    init_n = 1'b0; start = 1'b1; mem_ack = 1'b0;
    step();
    out_chk("rst mid mem", S_IDLE, 0, 0);
    ir_chk("rst mid ir", 9'd0);
    init_n = 1'b1;
    cyc("rst ack1", 0, 0, 1, S_IDLE, 0, 0);
    cyc("rst ack2", 0, 0, 1, S_IDLE, 0, 0);

    // Randomized programs
    for (int p = 0; p < 40; p++) begin
      for (int a = 0; a < 8; a++) rom[a] = 9'($urandom);
      do_reset("rnd reset");
      rnd_run(30, h);
      if (h && ($urandom % 2) == 1) rnd_run(30, h);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
